// File: rtl/hms_time_counter.sv
// Purpose: time-of-day core holding sec/min/hour, advanced by an internal 1 Hz prescaler, with manual per-field setting.
// Latency: all outputs registered; field updates, o_tick and o_day_wrap become visible one clk after the deciding edge.
// Backpressure: none; free-running datapath, inputs are sampled every cycle and never stalled.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   i_mode       0 = run (timekeeping), 1 = set
//   i_position   set-mode field select: 0 sec, 1 min, 2 hour, 3 none
//   i_inc        debounced increment button level (rising edge used)
//   o_sec/o_min  0..59
//   o_hour       0..23
//   o_tick       one-cycle pulse per elapsed second (run mode only)
//   o_day_wrap   one-cycle pulse on 23:59:59 -> 00:00:00
module hms_time_counter #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int PRE_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode,
  input  logic [1:0] i_position,
  input  logic       i_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hour,
  output logic       o_tick,
  output logic       o_day_wrap
);

  localparam logic [PRE_W-1:0] LP_PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [5:0]       LP_SEC_LAST = 6'd59;
  localparam logic [5:0]       LP_MIN_LAST = 6'd59;
  localparam logic [5:0]       LP_HOUR_LAST = 6'd23;

  logic [PRE_W-1:0] r_pre;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [5:0]       r_hour;
  logic             r_tick;
  logic             r_day_wrap;
  logic             r_inc_d;

  logic             w_pre_wrap;
  logic             w_inc_pulse;
  logic [5:0]       w_sec_nxt;
  logic [5:0]       w_min_nxt;
  logic [5:0]       w_hour_nxt;
  logic             w_day_wrap_nxt;

  // Increment with wrap inside the field. Anything at or above the last
  // legal value (including unreachable out-of-range codes) reloads 0.
  function automatic logic [5:0] f_inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v >= last) ? 6'd0 : (v + 6'd1);
  endfunction

  // >= rather than == so a corrupted prescaler value still returns to 0.
  assign w_pre_wrap  = ~i_mode & (r_pre >= LP_PRE_LAST);
  assign w_inc_pulse = i_inc & ~r_inc_d;

  always_comb begin
    w_sec_nxt      = r_sec;
    w_min_nxt      = r_min;
    w_hour_nxt     = r_hour;
    w_day_wrap_nxt = 1'b0;
    if (w_pre_wrap) begin
      // Whole carry chain resolves in one edge so no partial time is shown.
      w_sec_nxt = f_inc_wrap(r_sec, LP_SEC_LAST);
      if (r_sec == LP_SEC_LAST) begin
        w_min_nxt = f_inc_wrap(r_min, LP_MIN_LAST);
        if (r_min == LP_MIN_LAST) begin
          w_hour_nxt = f_inc_wrap(r_hour, LP_HOUR_LAST);
          if (r_hour == LP_HOUR_LAST) begin
            w_day_wrap_nxt = 1'b1;
          end
        end
      end
    end else if (i_mode && w_inc_pulse) begin
      // Set mode: selected field only, never carries.
      case (i_position)
        2'd0:    w_sec_nxt  = f_inc_wrap(r_sec, LP_SEC_LAST);
        2'd1:    w_min_nxt  = f_inc_wrap(r_min, LP_MIN_LAST);
        2'd2:    w_hour_nxt = f_inc_wrap(r_hour, LP_HOUR_LAST);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre      <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_inc_d    <= 1'b0;
    end else begin
      // Tracked in both modes so a button already held across a mode
      // switch does not count as a fresh press.
      r_inc_d <= i_inc;
      if (i_mode || w_pre_wrap) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_tick     <= w_pre_wrap;
      r_day_wrap <= w_day_wrap_nxt;
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_hour     <= w_hour_nxt;
    end
  end

  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_hour     = r_hour;
  assign o_tick     = r_tick;
  assign o_day_wrap = r_day_wrap;

endmodule

// File: tb/tb_hms_time_counter.sv
// Purpose: self-checking bench for hms_time_counter against a seconds-of-day reference model.
// Latency: model advanced once per clk edge; outputs compared on the following falling edge.
// Backpressure: none; bench drives inputs every cycle.
module tb_hms_time_counter;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_mode;
  logic [1:0] i_position;
  logic       i_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [5:0] o_hour;
  logic       o_tick;
  logic       o_day_wrap;

  int total = 0;
  int bad   = 0;

  // Reference model: time as seconds since midnight, plus a count of
  // consecutive run-mode cycles since the last second boundary.
  int m_tod;
  int m_run_cnt;
  bit m_inc_d;
  bit m_tick;
  bit m_wrap;

  hms_time_counter #(.CLK_PER_SEC(CPS), .PRE_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mode     (i_mode),
    .i_position (i_position),
    .i_inc      (i_inc),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_tick     (o_tick),
    .o_day_wrap (o_day_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pulse;
    int h, m, s;
    if (!rst_n) begin
      m_tod = 0; m_run_cnt = 0; m_inc_d = 0; m_tick = 0; m_wrap = 0;
      return;
    end
    pulse   = i_inc && !m_inc_d;
    m_inc_d = i_inc;
    m_tick  = 0;
    m_wrap  = 0;
    if (!i_mode) begin
      m_run_cnt++;
      if (m_run_cnt == CPS) begin
        m_run_cnt = 0;
        m_tick    = 1;
        if (m_tod == 86399) m_wrap = 1;
        m_tod = (m_tod + 1) % 86400;
      end
    end else begin
      m_run_cnt = 0;
      if (pulse) begin
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        case (i_position)
          2'd0: s = (s + 1) % 60;
          2'd1: m = (m + 1) % 60;
          2'd2: h = (h + 1) % 24;
          default: ;
        endcase
        m_tod = h * 3600 + m * 60 + s;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sec",  o_sec,      m_tod % 60);
    chk("min",  o_min,      (m_tod / 60) % 60);
    chk("hour", o_hour,     m_tod / 3600);
    chk("tick", o_tick,     m_tick);
    chk("wrap", o_day_wrap, m_wrap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [1:0] pos);
    i_mode = 1'b1; i_position = pos; i_inc = 1'b1;
    step(); step();
    i_inc = 1'b0;
    step(); step();
  endtask

  task automatic set_from_zero(input int h, input int m, input int s);
    repeat (h) press(2'd2);
    repeat (m) press(2'd1);
    repeat (s) press(2'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_mode = 1'b0; i_position = 2'd3; i_inc = 1'b0;
    m_tod = 0; m_run_cnt = 0; m_inc_d = 0; m_tick = 0; m_wrap = 0;

    // Reset state
    do_reset();
    chk("rst_sec", o_sec, 0);
    chk("rst_tick", o_tick, 0);

    // Run 12 cycles: ticks at 4, 8, 12
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("tp1_tick_cyc", o_tick, (c % 4 == 0) ? 1 : 0);
    end
    chk("tp1_sec", o_sec, 3);
    chk("tp1_min", o_min, 0);

    // 60 second presses wrap sec back to 0 without carry
    do_reset();
    repeat (59) press(2'd0);
    chk("tp2_sec59", o_sec, 59);
    press(2'd0);
    chk("tp2_sec0", o_sec, 0);
    chk("tp2_min", o_min, 0);

    // Day wrap from 23:59:58
    do_reset();
    set_from_zero(23, 59, 58);
    i_mode = 1'b0;
    repeat (4) step();
    chk("tp3_sec59", o_sec, 59);
    repeat (3) step();
    chk("tp3_wrap_early", o_day_wrap, 0);
    step();
    chk("tp3_wrap", o_day_wrap, 1);
    chk("tp3_hour0", o_hour, 0);
    step();
    chk("tp3_wrap_one", o_day_wrap, 0);

    // Hour carry from 00:59:59
    do_reset();
    set_from_zero(0, 59, 59);
    i_mode = 1'b0;
    repeat (4) step();
    chk("tp4_hour", o_hour, 1);
    chk("tp4_min", o_min, 0);
    chk("tp4_sec", o_sec, 0);

    // Held button gives exactly one increment; position change while held gives none
    do_reset();
    i_mode = 1'b1; i_position = 2'd2; i_inc = 1'b1;
    repeat (20) step();
    chk("tp5_hour", o_hour, 1);
    i_position = 2'd1;
    repeat (5) step();
    chk("tp5_min_held", o_min, 0);
    i_inc = 1'b0; step();
    i_inc = 1'b1; step();
    chk("tp5_min_press", o_min, 1);
    i_inc = 1'b0; step();

    // Mode switch with button already high: no increment
    i_mode = 1'b0; i_inc = 1'b1; step();
    i_mode = 1'b1; i_position = 2'd0; step();
    chk("mode_sw_sec", o_sec, 0);
    i_inc = 1'b0; step();

    // Reset mid-prescaler at 12:34:56
    do_reset();
    set_from_zero(12, 34, 56);
    i_mode = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("tp6_hour", o_hour, 0);
    chk("tp6_sec", o_sec, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("tp6_tick_early", o_tick, 0);
    step();
    chk("tp6_tick", o_tick, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) i_mode = ~i_mode;
      if ($urandom_range(0, 9) == 0) i_position = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) i_inc = ~i_inc;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
